// File: rtl/regfile_sb.sv
// regfile_sb - multi-ported register file with a scoreboard.
//
// This is a register file of NR = 2**ADDR_WIDTH registers, each DW = 2**DATA_WIDTH_POW
// bits wide. Every register has a "pending" bit. An instruction issue reserves its
// destination register, and the reservation stays until a write to that register
// retires it. Register 0 always reads as zero, ignores writes and is never pending.
//
// Optional feature (define the macro REGFILE_SB_BYPASS_EN to enable it):
//   Same-cycle write data is forwarded to the read ports. When the macro is not
//   defined, reads return stored state only.
//
// Ports:
//   clk_in          clock; all state changes on the rising edge
//   reset           synchronous, active-high; clears registers, pending bits and count
//   rs_in           READ_PORTS packed read register numbers (port p = slice p)
//   rdata_out       READ_PORTS packed read data (combinational)
//   rvalid_out      per read port: 1 when the register is not awaiting a write
//   we_in           per write port enable
//   wrd_in          WRITE_PORTS packed write destination numbers
//   wdata_in        WRITE_PORTS packed write data
//   resv_en_in      request to reserve resv_rd_in
//   resv_rd_in      register to reserve
//   resv_ready_out  1 when a reservation of resv_rd_in would be accepted this cycle
//   pend_count_out  number of registers currently pending
module regfile_sb #(
    parameter int DATA_WIDTH_POW = 6,
    parameter int ADDR_WIDTH     = 5,
    parameter int READ_PORTS     = 2,
    parameter int WRITE_PORTS    = 2
) (
    input  logic                                  clk_in,
    input  logic                                  reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]      rs_in,
    output logic [READ_PORTS*(2**DATA_WIDTH_POW)-1:0] rdata_out,
    output logic [READ_PORTS-1:0]                 rvalid_out,
    input  logic [WRITE_PORTS-1:0]                we_in,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0]     wrd_in,
    input  logic [WRITE_PORTS*(2**DATA_WIDTH_POW)-1:0] wdata_in,
    input  logic                                  resv_en_in,
    input  logic [ADDR_WIDTH-1:0]                 resv_rd_in,
    output logic                                  resv_ready_out,
    output logic [ADDR_WIDTH-1:0]                 pend_count_out
);

    localparam int DW = 2**DATA_WIDTH_POW;
    localparam int NR = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

    logic [DW-1:0]         regs [NR];
    logic [NR-1:0]         pending;
    logic [ADDR_WIDTH-1:0] pend_count;

    logic [ADDR_WIDTH-1:0] wr_addr [WRITE_PORTS];
    logic [DW-1:0]         wr_data [WRITE_PORTS];
    logic                  wr_ok   [WRITE_PORTS];
    logic [ADDR_WIDTH-1:0] rd_addr [READ_PORTS];

    logic                  resv_set;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic [ADDR_WIDTH:0]   cnt_next;

    // Unpack write ports; writes to register 0 are dropped here.
    always_comb begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
            wr_addr[w] = wrd_in[w*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data[w] = wdata_in[w*DW +: DW];
            wr_ok[w]   = we_in[w] && (wr_addr[w] != '0);
        end
    end

    // Ready looks only at the pending state already registered. A write
    // arriving in the same cycle does not release a WAW stall early.
    assign resv_ready_out = (resv_rd_in == '0) || !pending[resv_rd_in];
    assign resv_set       = resv_en_in && resv_ready_out && (resv_rd_in != '0);

    // Count distinct pending registers that this cycle's writes retire. When
    // two ports hit the same register, only the lowest port counts it. A
    // register that is reserved in the same cycle stays pending, so it is not
    // counted.
    always_comb begin
        clr_cnt = '0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            logic first;
            first = 1'b1;
            for (int v = 0; v < w; v++) begin
                if (wr_ok[v] && (wr_addr[v] == wr_addr[w])) first = 1'b0;
            end
            if (wr_ok[w] && first && pending[wr_addr[w]] &&
                !(resv_set && (resv_rd_in == wr_addr[w]))) begin
                clr_cnt = clr_cnt + ONE;
            end
        end
    end

    assign cnt_next = {1'b0, pend_count} + {{ADDR_WIDTH{1'b0}}, resv_set} - clr_cnt;

    // Register array. Ports are applied in ascending order, so the
    // highest-numbered port wins a same-register collision.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) regs[i] <= '0;
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_ok[w]) regs[wr_addr[w]] <= wr_data[w];
            end
        end
    end

    // Scoreboard. The set is applied after the clears, so a reservation wins
    // over a same-cycle write to the same register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_ok[w]) pending[wr_addr[w]] <= 1'b0;
            end
            if (resv_set) pending[resv_rd_in] <= 1'b1;
            pend_count <= cnt_next[ADDR_WIDTH-1:0];
        end
    end

    assign pend_count_out = pend_count;

    // Combinational read ports.
    always_comb begin
        rdata_out  = '0;
        rvalid_out = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_addr[p] = rs_in[p*ADDR_WIDTH +: ADDR_WIDTH];
            rdata_out[p*DW +: DW] = (rd_addr[p] == '0) ? '0 : regs[rd_addr[p]];
            rvalid_out[p]         = (rd_addr[p] == '0) || !pending[rd_addr[p]];
`ifdef REGFILE_SB_BYPASS_EN
            // Forward from the highest enabled port that targets this register.
            // A same-cycle accepted reservation keeps the register not-valid.
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_ok[w] && (wr_addr[w] == rd_addr[p])) begin
                    rdata_out[p*DW +: DW] = wr_data[w];
                    rvalid_out[p]         = !(resv_set && (resv_rd_in == rd_addr[p]));
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int DWP = 6;
    localparam int AW  = 5;
    localparam int RP  = 2;
    localparam int WP  = 2;
    localparam int DW  = 2**DWP;

    logic                 clk_in = 1'b0;
    logic                 reset;
    logic [RP*AW-1:0]     rs_in;
    logic [RP*DW-1:0]     rdata_out;
    logic [RP-1:0]        rvalid_out;
    logic [WP-1:0]        we_in;
    logic [WP*AW-1:0]     wrd_in;
    logic [WP*DW-1:0]     wdata_in;
    logic                 resv_en_in;
    logic [AW-1:0]        resv_rd_in;
    logic                 resv_ready_out;
    logic [AW-1:0]        pend_count_out;

    regfile_sb #(
        .DATA_WIDTH_POW(DWP), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP)
    ) dut (
        .clk_in(clk_in), .reset(reset), .rs_in(rs_in), .rdata_out(rdata_out),
        .rvalid_out(rvalid_out), .we_in(we_in), .wrd_in(wrd_in), .wdata_in(wdata_in),
        .resv_en_in(resv_en_in), .resv_rd_in(resv_rd_in),
        .resv_ready_out(resv_ready_out), .pend_count_out(pend_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic          rst;
        logic [AW-1:0] rs0, rs1;
        logic [1:0]    we;
        logic [AW-1:0] wrd0, wrd1;
        logic [63:0]   wd0, wd1;
        logic          ren;
        logic [AW-1:0] rrd;
        logic          chk;
        logic [63:0]   e_rd0;
        logic          e_v0;
        logic [63:0]   e_rd1;
        logic          e_v1;
        logic          e_rdy;
        logic [AW-1:0] e_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst;
        rs_in      = {v.rs1, v.rs0};
        we_in      = v.we;
        wrd_in     = {v.wrd1, v.wrd0};
        wdata_in   = {v.wd1, v.wd0};
        resv_en_in = v.ren;
        resv_rd_in = v.rrd;
    endtask

    task automatic idle();
        reset = 1'b0; rs_in = '0; we_in = '0; wrd_in = '0; wdata_in = '0;
        resv_en_in = 1'b0; resv_rd_in = '0;
    endtask

    initial begin
        //          rst rs0 rs1 we    wrd0 wrd1 wd0           wd1    ren rrd chk e_rd0          v0    e_rd1   v1    rdy   cnt
        vecs[0]  = '{1'b1, 0, 0, 2'b00, 0, 0, 64'h0, 64'h0, 1'b0, 0, 1'b0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1, 0};
        // Reset state; write x5 = DEADBEEF.
        vecs[1]  = '{1'b0, 1, 2, 2'b01, 5, 0, 64'hDEADBEEF, 64'h0, 1'b0, 0, 1'b1, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1, 0};
        // x5 visible; write x0 = 1234 is dropped.
        vecs[2]  = '{1'b0, 5, 0, 2'b01, 0, 0, 64'h1234, 64'h0, 1'b0, 0, 1'b1, 64'hDEADBEEF, 1'b1, 64'h0, 1'b1, 1'b1, 0};
        // x0 still 0; reserve x7.
        vecs[3]  = '{1'b0, 0, 7, 2'b00, 0, 0, 64'h0, 64'h0, 1'b1, 7, 1'b1, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1, 0};
        // x7 pending: rvalid 0, count 1, re-reserve stalls.
        vecs[4]  = '{1'b0, 7, 0, 2'b00, 0, 0, 64'h0, 64'h0, 1'b1, 7, 1'b1, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1};
        // Write x7 = 55 while the re-reserve still stalls (ready ignores same-cycle write).
        vecs[5]  = '{1'b0, 0, 0, 2'b01, 7, 0, 64'h55, 64'h0, 1'b1, 7, 1'b1, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 1};
        // x7 retired; both ports write x3 (AA, BB).
        vecs[6]  = '{1'b0, 7, 0, 2'b11, 3, 3, 64'hAA, 64'hBB, 1'b0, 0, 1'b1, 64'h55, 1'b1, 64'h0, 1'b1, 1'b1, 0};
        // x3 = BB; reserve x9 and write x9 = 77 together.
        vecs[7]  = '{1'b0, 3, 0, 2'b01, 9, 0, 64'h77, 64'h0, 1'b1, 9, 1'b1, 64'hBB, 1'b1, 64'h0, 1'b1, 1'b1, 0};
        // x9 = 77 but still pending; reserve x10.
        vecs[8]  = '{1'b0, 9, 7, 2'b00, 0, 0, 64'h0, 64'h0, 1'b1, 10, 1'b1, 64'h77, 1'b0, 64'h55, 1'b1, 1'b1, 1};
        // Two pending regs; both ports write x9 (retires one register, count -1).
        vecs[9]  = '{1'b0, 10, 0, 2'b11, 9, 9, 64'h1, 64'h2, 1'b0, 0, 1'b1, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1, 2};
        // x9 = 2 valid; stalled reserve of x10 while port 1 retires x10.
        vecs[10] = '{1'b0, 9, 7, 2'b10, 0, 10, 64'h0, 64'hCAFE, 1'b1, 10, 1'b1, 64'h2, 1'b1, 64'h55, 1'b1, 1'b0, 1};
        // x10 retired; write non-pending x6; reserve x11.
        vecs[11] = '{1'b0, 10, 5, 2'b01, 6, 0, 64'h66, 64'h0, 1'b1, 11, 1'b1, 64'hCAFE, 1'b1, 64'hDEADBEEF, 1'b1, 1'b1, 0};
        // Write non-pending x12; reserve x13.
        vecs[12] = '{1'b0, 6, 11, 2'b01, 12, 0, 64'h12, 64'h0, 1'b1, 13, 1'b1, 64'h66, 1'b1, 64'h0, 1'b0, 1'b1, 1};
        // Reset with x11, x13 pending; the write to x5 and the reserve of x14 are discarded.
        vecs[13] = '{1'b1, 13, 12, 2'b01, 5, 0, 64'hFF, 64'h0, 1'b1, 14, 1'b1, 64'h0, 1'b0, 64'h12, 1'b1, 1'b1, 2};
        // All clear; write to formerly pending x11 must not decrement.
        vecs[14] = '{1'b0, 13, 5, 2'b01, 11, 0, 64'h3, 64'h0, 1'b0, 14, 1'b1, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1, 0};
        vecs[15] = '{1'b0, 11, 14, 2'b00, 0, 0, 64'h0, 64'h0, 1'b0, 14, 1'b1, 64'h3, 1'b1, 64'h0, 1'b1, 1'b1, 0};

        idle();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_in);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk) begin
                check("rdata0", i, rdata_out[DW-1:0], vecs[i].e_rd0);
                check("rvalid0", i, 64'(rvalid_out[0]), 64'(vecs[i].e_v0));
                check("rdata1", i, rdata_out[2*DW-1:DW], vecs[i].e_rd1);
                check("rvalid1", i, 64'(rvalid_out[1]), 64'(vecs[i].e_v1));
                check("resv_ready", i, 64'(resv_ready_out), 64'(vecs[i].e_rdy));
                check("pend_count", i, 64'(pend_count_out), 64'(vecs[i].e_cnt));
            end
        end

        // Same-cycle forwarding: write x4 = 99 and read x4 in the same cycle.
        @(negedge clk_in);
        idle();
        rs_in  = {5'd0, 5'd4};
        we_in  = 2'b01;
        wrd_in = {5'd0, 5'd4};
        wdata_in = {64'h0, 64'h99};
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("bypass_same_cycle", 100, rdata_out[DW-1:0], 64'h99);
`else
        check("nobypass_same_cycle", 100, rdata_out[DW-1:0], 64'h0);
`endif
        check("x4_rvalid_same", 100, 64'(rvalid_out[0]), 64'h1);
        @(negedge clk_in);
        idle();
        rs_in = {5'd0, 5'd4};
        #1;
        check("x4_next_cycle", 101, rdata_out[DW-1:0], 64'h99);

        // Reserve and write x8 together while reading x8.
        @(negedge clk_in);
        idle();
        rs_in      = {5'd8, 5'd0};
        we_in      = 2'b10;
        wrd_in     = {5'd8, 5'd0};
        wdata_in   = {64'h88, 64'h0};
        resv_en_in = 1'b1;
        resv_rd_in = 5'd8;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        check("bypass_resv_data", 102, rdata_out[2*DW-1:DW], 64'h88);
        check("bypass_resv_valid", 102, 64'(rvalid_out[1]), 64'h0);
`else
        check("nobypass_resv_data", 102, rdata_out[2*DW-1:DW], 64'h0);
        check("nobypass_resv_valid", 102, 64'(rvalid_out[1]), 64'h1);
`endif
        @(negedge clk_in);
        idle();
        rs_in = {5'd8, 5'd0};
        #1;
        check("x8_stored", 103, rdata_out[2*DW-1:DW], 64'h88);
        check("x8_pending", 103, 64'(rvalid_out[1]), 64'h0);
        check("x8_count", 103, 64'(pend_count_out), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_WIDTH_POW, default 6; data width DW = 2**DATA_WIDTH_POW bits.
REQ-002 Parameter ADDR_WIDTH, default 5; register count NR = 2**ADDR_WIDTH.
REQ-003 Parameter READ_PORTS, default 2; independent read ports, range 1..4.
REQ-004 Parameter WRITE_PORTS, default 2; independent write ports, range 1..2.
REQ-005 clk_in  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 rs_in  input  READ_PORTS*ADDR_WIDTH  read register numbers; port p occupies slice p.
REQ-008 rdata_out  output  READ_PORTS*DW  read data per port.
REQ-009 rvalid_out  output  READ_PORTS  per port, 1 = data not awaiting a pending write.
REQ-010 we_in  input  WRITE_PORTS  per-port write enable.
REQ-011 wrd_in  input  WRITE_PORTS*ADDR_WIDTH  write destination register numbers.
REQ-012 wdata_in  input  WRITE_PORTS*DW  write data.
REQ-013 resv_en_in  input  1  request to mark resv_rd_in pending (instruction issue).
REQ-014 resv_rd_in  input  ADDR_WIDTH  register to reserve.
REQ-015 resv_ready_out  output  1  1 = reservation of resv_rd_in is accepted this cycle.
REQ-016 pend_count_out  output  ADDR_WIDTH  number of registers currently pending.

Function
REQ-017 Register 0 SHALL read as 0, ignore writes, never become pending, and always report rvalid 1.
REQ-018 Reads SHALL be combinational: rdata_out[p] = stored value of rs_in[p]; rvalid_out[p] = !pending[rs_in[p]].
REQ-019 Write port w SHALL update register wrd_in[w] at the clock edge when we_in[w]=1 and wrd_in[w]!=0.
REQ-020 Two write ports targeting the same nonzero register in one cycle: the higher-numbered port's data SHALL be stored.
REQ-021 Any accepted write to register r SHALL clear pending[r] at the same edge.
REQ-022 resv_ready_out = 1 when resv_rd_in is 0 or pending[resv_rd_in]=0; otherwise 0 (WAW stall).
REQ-023 A reservation is accepted when resv_en_in=1 and resv_ready_out=1; resv_rd_in!=0 then sets pending at the edge; reserving register 0 is a no-op accept.
REQ-024 Reservation and write to the same register in the same cycle: reservation SHALL win; register stores data and remains pending.
REQ-025 resv_ready_out SHALL consider only current-cycle pending state, not same-cycle writes.
REQ-026 pend_count_out SHALL equal the population count of pending bits after each edge, updated by +1 per accepted set and -1 per distinct cleared register, never wrapping (max NR-1).
REQ-027 Writes to non-pending registers SHALL be permitted and SHALL not change pend_count_out.

Reset
REQ-028 While reset=1 at an edge, all registers SHALL become 0, all pending bits 0, pend_count_out 0; writes and reservations that cycle are discarded.
REQ-029 After reset all rvalid_out SHALL be 1, rdata_out 0, resv_ready_out 1.
REQ-030 Reset asserted with pending registers outstanding SHALL clear them in one cycle; later writes to those registers SHALL not decrement the count.

Configuration
REQ-031 Macro REGFILE_SB_BYPASS_EN, when defined, SHALL forward same-cycle write data to reads: rdata_out[p] = wdata_in of the highest enabled write port with wrd_in = rs_in[p] != 0, and rvalid_out[p] = 1 unless a same-cycle reservation targets it.
REQ-032 Without REGFILE_SB_BYPASS_EN, reads SHALL return stored state only; written data visible and rvalid 1 from the following cycle.

Verification
REQ-033 Reset, then write 0xDEAD_BEEF to x5 on port 0, read x5 next cycle -> rdata 0xDEAD_BEEF, rvalid 1.
REQ-034 Write 0x1234 to x0 -> read x0 returns 0, pend_count_out 0.
REQ-035 Reserve x7 -> next cycle rvalid(x7)=0, pend_count 1, reserve x7 again -> resv_ready 0; write x7=0x55 -> next cycle rvalid 1, pend_count 0.
REQ-036 Ports 0 and 1 both write x3 (0xAA, 0xBB) same cycle -> x3 reads 0xBB.
REQ-037 Reserve x9 and write x9=0x77 same cycle -> x9 reads 0x77, rvalid 0, pend_count 1.
REQ-038 With REGFILE_SB_BYPASS_EN, write x4=0x99 and read x4 same cycle -> rdata 0x99 same cycle; without macro -> old value, 0x99 next cycle.
